// File: rtl/vp_text_pixel_serializer.sv
// vp_text_pixel_serializer
// Consumer end of the text-stage output interface. Each accepted word is one
// character row (bitmap plus resolved foreground/background colour indices).
// The row is serialised MSB-first as one 4-bit colour index per pixel tick.
// A one-entry holding buffer in front of the active shifter lets consecutive
// characters stream back to back without a gap between them.
module vp_text_pixel_serializer #(
  parameter int unsigned CHAR_WIDTH  = 16,
  parameter logic [3:0]  BLANK_COLOR = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  txt_foreground,
  input  logic [3:0]  txt_background,
  input  logic [15:0] txt_bitmap,
  input  logic        enabled,
  output logic        in_ready,
  input  logic        pixel_tick,
  input  logic        flush,
  output logic [3:0]  pixel_color,
  output logic        pixel_valid,
  output logic        underrun,
  output logic        overflow,
  input  logic        clear_flags
);

  localparam int unsigned        CNT_W    = (CHAR_WIDTH > 1) ? $clog2(CHAR_WIDTH) : 1;
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(CHAR_WIDTH - 1);

  // One character row as it travels through hold and active.
  typedef struct packed {
    logic [3:0]            fg;
    logic [3:0]            bg;
    logic [CHAR_WIDTH-1:0] bits;
  } char_row_t;

  // Payload registers (data only; their validity lives in the *_full flags).
  char_row_t        hold_q;
  char_row_t        act_q;
  char_row_t        in_row;

  // Control state.
  logic             hold_full_q,   hold_full_d;
  logic             active_full_q, active_full_d;
  logic [CNT_W-1:0] count_q,       count_d;
  logic [3:0]       color_q,       color_d;
  logic             valid_q,       valid_d;
  logic             underrun_q,    underrun_d;
  logic             overflow_q,    overflow_d;

  // Per-cycle events.
  logic             accept;
  logic             transfer;
  logic             shift;
  logic             last_tick;
  logic             underrun_evt;
  logic             overflow_evt;
  logic [3:0]       shift_color;

  // Ready depends only on registered state so upstream can use it freely.
  assign in_ready    = !hold_full_q;
  assign pixel_color = color_q;
  assign pixel_valid = valid_q;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

  // Pack the incoming word; only the low CHAR_WIDTH bitmap bits are meaningful.
  always_comb begin
    in_row.fg   = txt_foreground;
    in_row.bg   = txt_background;
    in_row.bits = txt_bitmap[CHAR_WIDTH-1:0];
  end

  // Decode this cycle's events; flush overrides every datapath movement.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch, otherwise an untaken path would infer a latch.
    accept       = 1'b0;
    transfer     = 1'b0;
    shift        = 1'b0;
    last_tick    = 1'b0;
    underrun_evt = 1'b0;
    overflow_evt = enabled && !in_ready;
    shift_color  = act_q.bits[CHAR_WIDTH-1] ? act_q.fg : act_q.bg;

    if (!flush) begin
      accept       = enabled && in_ready;
      shift        = pixel_tick && active_full_q;
      last_tick    = shift && (count_q == LAST_IDX);
      underrun_evt = pixel_tick && !active_full_q;
      // Hold moves forward when the shifter is idle or is emitting its last
      // pixel right now. Accept cannot coincide: hold is full here, so
      // in_ready is low.
      transfer     = hold_full_q && (!active_full_q || last_tick);
    end
  end

  // Next-state for buffer occupancy, bit counter, pixel output and flags.
  always_comb begin
    hold_full_d   = hold_full_q;
    active_full_d = active_full_q;
    count_d       = count_q;
    color_d       = color_q;
    valid_d       = 1'b0;

    if (flush) begin
      hold_full_d   = 1'b0;
      active_full_d = 1'b0;
      count_d       = '0;
      color_d       = BLANK_COLOR;
    end else begin
      // Hold occupancy: set on accept, cleared when its row moves to active.
      if (accept) begin
        hold_full_d = 1'b1;
      end else if (transfer) begin
        hold_full_d = 1'b0;
      end

      // Pixel output: a tick either emits a real pixel or reports starvation.
      if (shift) begin
        color_d = shift_color;
        valid_d = 1'b1;
      end else if (underrun_evt) begin
        color_d = BLANK_COLOR;
      end

      // Active occupancy and position. A transfer restarts at the MSB; the
      // last tick without a waiting row leaves the shifter idle.
      if (transfer) begin
        active_full_d = 1'b1;
        count_d       = '0;
      end else if (last_tick) begin
        active_full_d = 1'b0;
        count_d       = '0;
      end else if (shift) begin
        count_d = count_q + 1'b1;
      end
    end

    // Sticky flags: a new event in the clearing cycle wins over the clear.
    underrun_d = underrun_evt || (underrun_q && !clear_flags);
    overflow_d = overflow_evt || (overflow_q && !clear_flags);
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full_q   <= 1'b0;
      active_full_q <= 1'b0;
      count_q       <= '0;
      color_q       <= BLANK_COLOR;
      valid_q       <= 1'b0;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: sequential state is always written with non-blocking
      // assignments so every register samples the pre-edge values.
      hold_full_q   <= hold_full_d;
      active_full_q <= active_full_d;
      count_q       <= count_d;
      color_q       <= color_d;
      valid_q       <= valid_d;
      underrun_q    <= underrun_d;
      overflow_q    <= overflow_d;
    end
  end

  // Row payloads: load hold on accept, load/shift the active row.
  // NOTE: payload registers are not reset; they are only ever read while the
  // matching *_full flag is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= in_row;
    end
    if (transfer) begin
      act_q <= hold_q;
    end else if (shift) begin
      act_q.bits <= act_q.bits << 1;
    end
  end

endmodule

// File: doc/vp_text_pixel_serializer.md
Name: vp_text_pixel_serializer

Overview:
Consumer end of the text-stage output interface. Takes one 16-pixel character row (bitmap plus resolved foreground/background colour indices) per handshake. Shifts it out MSB-first as one 4-bit colour index per pixel tick toward the palette/mixer stage. A one-entry holding buffer sits in front of the active shifter so consecutive characters stream without gaps.

Parameters:
CHAR_WIDTH, 16, pixels per character row. Only the low CHAR_WIDTH bits of txt_bitmap are used.
BLANK_COLOR, 4'd0, colour index driven when no pixel is available.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
txt_foreground  input  4  colour index for bitmap bit = 1
txt_background  input  4  colour index for bitmap bit = 0
txt_bitmap  input  16  row bitmap; bit CHAR_WIDTH-1 is the leftmost pixel
enabled  input  1  input valid; word accepted when enabled && in_ready
in_ready  output  1  holding buffer empty
pixel_tick  input  1  advance one pixel (pixel-clock enable)
flush  input  1  synchronous discard of all buffered data (line/frame end)
pixel_color  output  4  current pixel colour index
pixel_valid  output  1  pixel_color carries a real pixel this cycle
underrun  output  1  sticky: tick arrived with no pixel available
overflow  output  1  sticky: enabled while in_ready = 0
clear_flags  input  1  clears underrun and overflow

Behaviour:
- Reset (reset = 0, asynchronous):
  - hold and active buffers empty, bit counter 0.
  - pixel_color = BLANK_COLOR; pixel_valid, underrun, overflow = 0.
  - in_ready = 1 once reset is released.
- in_ready = !hold_full. It is combinational from registers only and never depends on enabled.
- Accept: enabled && in_ready at a clock edge latches fg, bg and bitmap into hold; hold_full <= 1.
- Overflow: enabled && !in_ready drops the word and sets overflow. Hold contents are unchanged.
- Hold-to-active transfer:
  - Happens when hold_full && (!active_full || (pixel_tick && count == CHAR_WIDTH-1)).
  - Counter resets to 0, active_full <= 1, hold_full <= 0.
  - Accept and transfer never occur in the same cycle, because in_ready = 0 whenever hold is full.
- Shift: on pixel_tick with active_full at the clock edge:
  - pixel_color <= bitmap[CHAR_WIDTH-1-count] ? fg : bg.
  - pixel_valid <= 1.
  - count increments.
- Last pixel: on pixel_tick at count == CHAR_WIDTH-1 the last pixel is emitted. Then the next character is transferred if hold is full; otherwise active_full <= 0.
- Underrun: pixel_tick with !active_full at the edge gives pixel_valid <= 0, pixel_color <= BLANK_COLOR and sets underrun. This applies even if a transfer happens in that same cycle; the transferred character starts on the next tick.
- No tick: pixel_valid <= 0 and pixel_color holds its last value.
- Latency: pixel output is registered and appears one cycle after the pixel_tick edge. The minimum from accept to first pixel is accept (edge 0), transfer (edge 1), tick (edge 2), so the pixel is visible after edge 2.
- flush:
  - Priority over accept, transfer and shift. Clears hold_full, active_full and count.
  - Drives pixel_valid <= 0 and pixel_color <= BLANK_COLOR.
  - Does not touch the sticky flags. Any input offered in the flush cycle is not accepted.
- clear_flags: clears both flags. If a new underrun or overflow event occurs in the same cycle, the set wins.
- Reset mid-character: everything returns to reset values immediately. No partial pixels are emitted afterward.
- Steady state: one character per CHAR_WIDTH ticks, with ticks on consecutive cycles supported gap-free provided the next word is offered at least one cycle before the last tick.

Test Plan:
1. Reset asserted mid-stream -> pixel_color = 0, pixel_valid = 0, flags = 0 immediately; in_ready = 1 after release.
2. Load bitmap 16'hA5F0, fg = 4'hF, bg = 4'h1, then pixel_tick every cycle -> pixel_color sequence F,1,F,1, 1,F,1,F, F,F,F,F, 1,1,1,1, each with pixel_valid = 1, then pixel_valid = 0.
3. Load 16'hFFFF (fg = 2), then 16'h0000 (bg = 3) while the first is shifting, continuous ticks -> 16×2 then 16×3 with no gap; underrun stays 0; in_ready drops after the second accept and rises on the transfer.
4. Ticks with nothing loaded -> pixel_valid = 0, pixel_color = BLANK_COLOR, underrun = 1. Assert clear_flags -> underrun = 0 next cycle.
5. Fill hold while active is busy, then assert enabled with 16'h1234 -> overflow = 1; the held word is emitted unchanged and 16'h1234 never appears.
6. flush after 5 pixels of a character, with hold full -> no further valid pixels; in_ready = 1; the next loaded word starts from its MSB.
